// File: rtl/booth_rr_scheduler.sv
// Round-robin front end for one shared sequential signed Booth multiplier.
// Grants one requester at a time, sequences the multiplier's load/run and returns the tagged product.
module booth_rr_scheduler #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 9,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_m,
   input  logic [N_REQ*WIDTH-1:0] req_q,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]     rsp_z,
   output logic [WIDTH-1:0]       mul_m,
   output logic [WIDTH-1:0]       mul_q,
   output logic                   mul_rst,
   input  logic [2*WIDTH-1:0]     mul_z,
   output logic                   busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam int              CNT_W    = $clog2(MUL_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [2*WIDTH-1:0] rsp_z_q, rsp_z_d;
   logic [WIDTH-1:0]   mul_m_q, mul_m_d;
   logic [WIDTH-1:0]   mul_q_q, mul_q_d;
   logic               mul_rst_q, mul_rst_d;
   logic               busy_q, busy_d;

   logic [ID_W-1:0]    grant_s;
   logic               found_s;
   logic [WIDTH-1:0]   sel_m_s;
   logic [WIDTH-1:0]   sel_q_s;
   int                 dist_s;
   int                 best_s;
   logic               take_s;

   // Round-robin pick: the valid requester at the smallest distance past last_grant wins.
   always_comb begin
      grant_s = '0;
      found_s = 1'b0;
      sel_m_s = '0;
      sel_q_s = '0;
      dist_s  = 0;
      best_s  = N_REQ;
      take_s  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         dist_s  = (i > int'(last_grant_q)) ? (i - int'(last_grant_q) - 1)
                                            : (i - int'(last_grant_q) - 1 + N_REQ);
         take_s  = req_valid[i] && (dist_s < best_s);
         best_s  = take_s ? dist_s : best_s;
         grant_s = take_s ? ID_W'(i) : grant_s;
         found_s = take_s | found_s;
         sel_m_s = take_s ? req_m[i*WIDTH +: WIDTH] : sel_m_s;
         sel_q_s = take_s ? req_q[i*WIDTH +: WIDTH] : sel_q_s;
      end
   end

   // Accept strobe is combinational so a requester sees it in the same IDLE cycle.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = (state_q == ST_IDLE) && found_s && (grant_s == ID_W'(i));
      end
   end

   // Sequencing: IDLE accept -> LOAD (multiplier held in reset) -> RUN count -> RESP hold.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_z_d      = rsp_z_q;
      mul_m_d      = mul_m_q;
      mul_q_d      = mul_q_q;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               mul_m_d  = sel_m_s;
               mul_q_d  = sel_q_s;
               rsp_id_d = grant_s;
               state_d  = ST_LOAD;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (cnt_q == CNT_LAST) begin
               rsp_z_d     = mul_z;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d       = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d  = 1'b0;
               last_grant_d = rsp_id_q;
               state_d      = ST_IDLE;
            end else begin
               state_d      = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      mul_rst_d = (state_d != ST_RUN);
      busy_d    = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_grant_q <= LAST_RST;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_z_q      <= '0;
         mul_m_q      <= '0;
         mul_q_q      <= '0;
         mul_rst_q    <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_z_q      <= rsp_z_d;
         mul_m_q      <= mul_m_d;
         mul_q_q      <= mul_q_d;
         mul_rst_q    <= mul_rst_d;
         busy_q       <= busy_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_z     = rsp_z_q;
   assign mul_m     = mul_m_q;
   assign mul_q     = mul_q_q;
   assign mul_rst   = mul_rst_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_booth_rr_scheduler.sv
// Bench for booth_rr_scheduler: a behavioural radix-2 Booth datapath plus a per-transaction scoreboard.
module tb_booth_rr_scheduler;
   localparam int N_REQ   = 4;
   localparam int WIDTH   = 8;
   localparam int MUL_LAT = 9;
   localparam int ID_W    = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_m, req_q;
   logic [N_REQ-1:0]       req_ready;
   logic                   rsp_valid, rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [2*WIDTH-1:0]     rsp_z;
   logic [WIDTH-1:0]       mul_m, mul_q;
   logic                   mul_rst;
   logic [2*WIDTH-1:0]     mul_z;
   logic                   busy;

   logic [7:0]  m_arr [N_REQ];
   logic [7:0]  q_arr [N_REQ];
   logic [3:0]  hold_mask;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ready_hi_cnt = 0;
   int mulrst_lo_cnt = 0;
   logic prev_rsp_valid = 1'b0;

   int          acc_id_q[$];
   int          acc_cyc_q[$];
   int          exp_id_q[$];
   logic [15:0] exp_z_q[$];
   int          rsp_id_q[$];
   logic [15:0] rsp_z_q[$];
   int          rsp_cyc_q[$];
   int          rise_q[$];

   always #5 clk = ~clk;

   always_comb begin
      req_m = '0;
      req_q = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_m[i*WIDTH +: WIDTH] = m_arr[i];
         req_q[i*WIDTH +: WIDTH] = q_arr[i];
      end
   end

   booth_rr_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_m(req_m), .req_q(req_q),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_z(rsp_z), .mul_m(mul_m), .mul_q(mul_q), .mul_rst(mul_rst), .mul_z(mul_z), .busy(busy)
   );

   // Shared datapath: 8 Booth iterations after mul_rst drops, then holds the product.
   logic [8:0]  b_a;
   logic [7:0]  b_q;
   logic        b_q1;
   int          b_cnt;
   logic [8:0]  b_sum;
   logic [17:0] b_sh;

   always_comb begin
      b_sum = b_a;
      case ({b_q[0], b_q1})
         2'b01:   b_sum = b_a + {mul_m[7], mul_m};
         2'b10:   b_sum = b_a - {mul_m[7], mul_m};
         default: b_sum = b_a;
      endcase
      b_sh = {b_sum[8], b_sum, b_q};
   end

   always @(posedge clk) begin
      if (mul_rst) begin
         b_a <= '0; b_q <= mul_q; b_q1 <= 1'b0; b_cnt <= 0;
      end else if (b_cnt < 8) begin
         b_a <= b_sh[17:9]; b_q <= b_sh[8:1]; b_q1 <= b_sh[0]; b_cnt <= b_cnt + 1;
      end
   end

   assign mul_z = {b_a[7:0], b_q};

   function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[15:0];
   endfunction

   task automatic clear_logs();
      acc_id_q.delete(); acc_cyc_q.delete(); exp_id_q.delete(); exp_z_q.delete();
      rsp_id_q.delete(); rsp_z_q.delete(); rsp_cyc_q.delete(); rise_q.delete();
      ready_hi_cnt = 0; mulrst_lo_cnt = 0;
   endtask

   // One clock: observe handshakes on the negedge, advance past the posedge, retire accepted requests.
   task automatic step();
      int acc;
      acc = -1;
      @(negedge clk);
      cyc++;
      if (req_ready != '0) ready_hi_cnt++;
      if (!mul_rst) mulrst_lo_cnt++;
      for (int i = 0; i < N_REQ; i++) if (req_valid[i] && req_ready[i]) acc = i;
      if (acc >= 0 && !rst) begin
         acc_id_q.push_back(acc);
         acc_cyc_q.push_back(cyc);
         exp_id_q.push_back(acc);
         exp_z_q.push_back(prod(m_arr[acc], q_arr[acc]));
      end
      if (rsp_valid && !prev_rsp_valid) rise_q.push_back(cyc - 1);
      prev_rsp_valid = rsp_valid;
      if (rsp_valid && rsp_ready && !rst) begin
         rsp_id_q.push_back(int'(rsp_id));
         rsp_z_q.push_back(rsp_z);
         rsp_cyc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (acc >= 0 && !rst && !hold_mask[acc]) req_valid[acc] = 1'b0;
   endtask

   task automatic wait_rsp(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (rsp_id_q.size() < n && k < budget) begin
         step();
         k++;
      end
      ok = (rsp_id_q.size() >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
      checks++; if (rsp_z !== 16'h0000) begin errors++; $display("FAIL reset_rsp_z got=%h want=0000", rsp_z); end
      checks++; if ({mul_m, mul_q} !== 16'h0000) begin errors++; $display("FAIL reset_mul_mq got=%h want=0000", {mul_m, mul_q}); end
      checks++; if (mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mul_rst got=%b want=1", mul_rst); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      rst = 1'b0;
      step();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_single();
      bit ok;
      clear_logs();
      m_arr[0] = 8'd15; q_arr[0] = 8'd15; req_valid[0] = 1'b1;
      wait_rsp(1, 40, ok);
      step();
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=%0d rsp want=1", rsp_id_q.size()); end
      if (ok) begin
         checks++; if (ready_hi_cnt != 1) begin errors++; $display("FAIL single_ready_cycles got=%0d want=1", ready_hi_cnt); end
         checks++; if (rise_q[0] - acc_cyc_q[0] != MUL_LAT + 1) begin errors++; $display("FAIL single_latency got=%0d want=%0d", rise_q[0] - acc_cyc_q[0], MUL_LAT + 1); end
         checks++; if (mulrst_lo_cnt != MUL_LAT) begin errors++; $display("FAIL single_run_cycles got=%0d want=%0d", mulrst_lo_cnt, MUL_LAT); end
         checks++; if (rsp_z_q[0] !== 16'd225) begin errors++; $display("FAIL single_z got=%h want=%h", rsp_z_q[0], 16'd225); end
         checks++; if (rsp_id_q[0] != 0) begin errors++; $display("FAIL single_id got=%0d want=0", rsp_id_q[0]); end
      end
   endtask

   task automatic test_signed();
      int          ids [3] = '{1, 2, 3};
      logic [7:0]  ms  [3] = '{8'hFD, 8'hFF, 8'h00};
      logic [7:0]  qs  [3] = '{8'h06, 8'h06, 8'h01};
      logic [15:0] zs  [3] = '{16'hFFEE, 16'hFFFA, 16'h0000};
      bit ok;
      clear_logs();
      for (int t = 0; t < 3; t++) begin
         m_arr[ids[t]] = ms[t]; q_arr[ids[t]] = qs[t]; req_valid[ids[t]] = 1'b1;
         wait_rsp(t + 1, 40, ok);
         checks++; if (!ok) begin errors++; $display("FAIL signed_timeout_%0d got=%0d want=%0d", t, rsp_id_q.size(), t + 1); end
         if (ok) begin
            checks++; if (rsp_z_q[t] !== zs[t]) begin errors++; $display("FAIL signed_z_%0d got=%h want=%h", t, rsp_z_q[t], zs[t]); end
            checks++; if (rsp_id_q[t] != ids[t]) begin errors++; $display("FAIL signed_id_%0d got=%0d want=%0d", t, rsp_id_q[t], ids[t]); end
         end
      end
   endtask

   task automatic test_all_four();
      bit ok;
      clear_logs();
      for (int i = 0; i < N_REQ; i++) begin m_arr[i] = 8'd1; q_arr[i] = 8'(i + 2); end
      req_valid = 4'hF;
      wait_rsp(4, 200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL all4_timeout got=%0d want=4", rsp_id_q.size()); end
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (acc_id_q[i] != i) begin errors++; $display("FAIL all4_grant_%0d got=%0d want=%0d", i, acc_id_q[i], i); end
            checks++; if (rsp_z_q[i] !== 16'(i + 2) || rsp_id_q[i] != exp_id_q[i] || rsp_z_q[i] !== exp_z_q[i]) begin
               errors++; $display("FAIL all4_rsp_%0d got=%0d/%h want=%0d/%h", i, rsp_id_q[i], rsp_z_q[i], exp_id_q[i], exp_z_q[i]); end
            if (i > 0) begin
               checks++; if (rsp_cyc_q[i] - rsp_cyc_q[i-1] != MUL_LAT + 3) begin errors++; $display("FAIL all4_period_%0d got=%0d want=%0d", i, rsp_cyc_q[i] - rsp_cyc_q[i-1], MUL_LAT + 3); end
            end
         end
      end
   endtask

   task automatic test_fairness();
      bit ok;
      clear_logs();
      m_arr[0] = 8'd3;   q_arr[0] = 8'hFE;
      m_arr[2] = 8'hFB;  q_arr[2] = 8'hF9;
      hold_mask = 4'b0101;
      req_valid = 4'b0101;
      wait_rsp(6, 200, ok);
      req_valid = 4'b0000;
      hold_mask = 4'b0000;
      checks++; if (!ok || acc_id_q.size() != 6) begin errors++; $display("FAIL fair_count got=%0d want=6", acc_id_q.size()); end
      if (ok) begin
         for (int i = 0; i < 6; i++) begin
            checks++; if (acc_id_q[i] != ((i % 2) * 2)) begin errors++; $display("FAIL fair_grant_%0d got=%0d want=%0d", i, acc_id_q[i], (i % 2) * 2); end
            checks++; if (rsp_z_q[i] !== exp_z_q[i] || rsp_id_q[i] != exp_id_q[i]) begin
               errors++; $display("FAIL fair_rsp_%0d got=%0d/%h want=%0d/%h", i, rsp_id_q[i], rsp_z_q[i], exp_id_q[i], exp_z_q[i]); end
         end
         checks++; if (exp_z_q[1] !== 16'd35) begin errors++; $display("FAIL fair_ref got=%h want=0023", exp_z_q[1]); end
      end
   endtask

   task automatic test_back_pressure();
      bit ok;
      int k;
      clear_logs();
      rsp_ready = 1'b0;
      m_arr[1] = 8'd7; q_arr[1] = 8'hF8; req_valid[1] = 1'b1;
      k = 0;
      while (acc_id_q.size() == 0 && k < 10) begin step(); k++; end
      m_arr[0] = 8'd2; q_arr[0] = 8'd2; req_valid[0] = 1'b1;
      k = 0;
      while (!rsp_valid && k < 30) begin step(); k++; end
      checks++; if (!rsp_valid) begin errors++; $display("FAIL bp_no_valid got=%b want=1", rsp_valid); end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if ({rsp_valid, busy} !== 2'b11 || rsp_z !== 16'hFFC8 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_hold_%0d got=v%b b%b z%h id%0d rdy%b want=v1 b1 zffc8 id1 rdy0000", i, rsp_valid, busy, rsp_z, rsp_id, req_ready); end
      end
      rsp_ready = 1'b1;
      wait_rsp(2, 60, ok);
      checks++; if (!ok || acc_id_q.size() != 2) begin errors++; $display("FAIL bp_timeout got=%0d want=2", rsp_id_q.size()); end
      if (ok && acc_id_q.size() == 2) begin
         checks++; if (rsp_z_q[0] !== 16'hFFC8 || rsp_id_q[0] != 1) begin errors++; $display("FAIL bp_first got=%0d/%h want=1/ffc8", rsp_id_q[0], rsp_z_q[0]); end
         checks++; if (acc_id_q[1] != 0 || acc_cyc_q[1] != rsp_cyc_q[0] + 1) begin errors++; $display("FAIL bp_next_accept got=id%0d@%0d want=id0@%0d", acc_id_q[1], acc_cyc_q[1], rsp_cyc_q[0] + 1); end
         checks++; if (rsp_z_q[1] !== exp_z_q[1]) begin errors++; $display("FAIL bp_second got=%h want=%h", rsp_z_q[1], exp_z_q[1]); end
      end
   endtask

   task automatic test_reset_midrun();
      bit ok;
      int k;
      clear_logs();
      m_arr[1] = 8'hF0; q_arr[1] = 8'd2;
      m_arr[2] = 8'd9;  q_arr[2] = 8'd9;
      m_arr[3] = 8'd3;  q_arr[3] = 8'd3;
      req_valid = 4'b1100;
      k = 0;
      while (acc_id_q.size() == 0 && k < 10) begin step(); k++; end
      checks++; if (acc_id_q.size() != 1 || acc_id_q[0] != 2) begin errors++; $display("FAIL mid_first_grant got=%0d accepts want=id2", acc_id_q.size()); end
      repeat (4) step();
      req_valid[1] = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if ({rsp_valid, mul_rst, busy} !== 3'b010 || rsp_id !== 2'd0 || rsp_z !== 16'h0000 || {mul_m, mul_q} !== 16'h0000) begin
         errors++; $display("FAIL mid_reset_state got=v%b mr%b b%b id%0d z%h mq%h want=v0 mr1 b0 id0 z0000 mq0000", rsp_valid, mul_rst, busy, rsp_id, rsp_z, {mul_m, mul_q}); end
      clear_logs();
      wait_rsp(2, 80, ok);
      checks++; if (!ok || acc_id_q.size() != 2) begin errors++; $display("FAIL mid_timeout got=%0d want=2", rsp_id_q.size()); end
      if (ok && acc_id_q.size() == 2) begin
         checks++; if (acc_id_q[0] != 1 || acc_id_q[1] != 3) begin errors++; $display("FAIL mid_grants got=%0d,%0d want=1,3", acc_id_q[0], acc_id_q[1]); end
         checks++; if (rsp_id_q[0] != 1 || rsp_z_q[0] !== 16'hFFE0) begin errors++; $display("FAIL mid_rsp0 got=%0d/%h want=1/ffe0", rsp_id_q[0], rsp_z_q[0]); end
         checks++; if (rsp_id_q[1] != exp_id_q[1] || rsp_z_q[1] !== 16'd9) begin errors++; $display("FAIL mid_rsp1 got=%0d/%h want=3/0009", rsp_id_q[1], rsp_z_q[1]); end
      end
   endtask

   initial begin
      rst = 1'b1;
      rsp_ready = 1'b1;
      req_valid = '0;
      hold_mask = '0;
      for (int i = 0; i < N_REQ; i++) begin m_arr[i] = '0; q_arr[i] = '0; end
      test_reset();
      test_single();
      test_signed();
      test_all_four();
      test_fairness();
      test_back_pressure();
      test_reset_midrun();
      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/booth_rr_scheduler.md
Name: booth_rr_scheduler

Overview:
Shares one sequential 8x8 signed Booth multiplier between N_REQ requesters using round-robin arbitration and a valid/ready handshake on each side. The block accepts one operand pair, and loads it by pulsing the multiplier's reset with the operands stable. It then waits a fixed iteration count, captures the 16-bit product and returns it tagged with the requester id. It sits between the client ports and the shared Booth datapath, and is the only driver of that datapath's M/Q/rst inputs.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand width; product is 2*WIDTH
MUL_LAT, 9, clock cycles after mul_rst deasserts until mul_z holds the final product
ID_W, 2, width of rsp_id (clog2 of N_REQ)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request valid
req_m  in  N_REQ*WIDTH  multiplicands, requester i at bits [i*WIDTH +: WIDTH], two's complement
req_q  in  N_REQ*WIDTH  multipliers, same packing
req_ready  out  N_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
rsp_valid  out  1  product valid
rsp_ready  in  1  consumer accepts product
rsp_id  out  ID_W  requester index of rsp_z
rsp_z  out  2*WIDTH  signed product
mul_m  out  WIDTH  to multiplier M
mul_q  out  WIDTH  to multiplier Q
mul_rst  out  1  to multiplier rst (load/hold)
mul_z  in  2*WIDTH  from multiplier Z
busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, LOAD, RUN, RESP. All state, counters and outputs are registered except req_ready. req_ready is combinational from state, pointer and req_valid.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_z=0, mul_m=0, mul_q=0, mul_rst=1, busy=0, req_ready=0, last_grant=N_REQ-1, so requester 0 has first priority.
- IDLE: if any req_valid is high, the grant is the first set bit searching from last_grant+1 upward with wrap. req_ready[grant]=1 in that cycle only. On the clock edge, latch req_m/req_q[grant] into mul_m/mul_q, store grant as rsp_id, and go to LOAD. If no requests, stay in IDLE. req_ready is 0 in all other states.
- LOAD: one cycle, mul_rst=1, operands stable. Then go to RUN and clear the wait counter.
- RUN: mul_rst=0. The counter increments every cycle. When it reaches MUL_LAT-1, capture mul_z into rsp_z, set rsp_valid=1 and go to RESP. mul_m/mul_q stay constant throughout.
- RESP: mul_rst=1. rsp_valid, rsp_z and rsp_id are held stable until rsp_ready=1. On the handshake edge: rsp_valid=0, last_grant=rsp_id, go to IDLE.
- mul_rst=1 in IDLE, LOAD and RESP; 0 only in RUN.
- Latency from the accept edge to rsp_valid high is MUL_LAT+1 cycles (LOAD + MUL_LAT RUN cycles). With rsp_ready tied high, one product is delivered every MUL_LAT+3 cycles.
- Requester rules: req_valid and operands must stay stable until accepted. Dropping req_valid before accept is legal and means the request is simply not granted.
- Simultaneous events: requests arriving during LOAD/RUN/RESP wait and are arbitrated in the next IDLE cycle. A new request on the same edge as the RESP handshake is seen in the following IDLE cycle, so there is no overlap.
- Pointer wrap: the search from last_grant+1 wraps from N_REQ-1 to 0.
- A single continuously requesting client is re-granted each time. Two or more continuous requesters strictly alternate by index order.
- Arithmetic: products are signed two's complement, 2*WIDTH bits, and are passed through unmodified from mul_z.
- Reset mid-operation: any state returns to reset values on the next edge. The in-flight product is discarded with no response. The pointer resets, so requester 0 has priority again.

Test Plan:
- Single req0, m=15, q=15, rsp_ready=1 -> req_ready[0] for exactly 1 cycle; rsp_valid rises MUL_LAT+1 cycles after accept; rsp_z=16'd225, rsp_id=0.
- Signed operands: req1 m=-3 (8'hFD), q=6 -> rsp_z=16'hFFEE (-18), rsp_id=1. Also req2 m=-1, q=6 -> 16'hFFFA. Also m=0, q=1 -> 16'h0000.
- All 4 requesters valid at once, each holding until accepted, operands (1,2),(1,3),(1,4),(1,5) -> grants in order 0,1,2,3; responses 2,3,4,5 with matching ids; one response every MUL_LAT+3 cycles.
- Fairness: req0 and req2 held valid continuously for 6 transactions -> grant sequence 0,2,0,2,0,2; req1 and req3 are never granted.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_valid, rsp_z and rsp_id stay constant, busy=1, all req_ready=0, and no new accept until one cycle after the handshake.
- Reset for one cycle during RUN while req3 is also pending -> next cycle all outputs are at reset values with mul_rst=1; no response for the aborted job; the next grant goes to the lowest pending index searching from 0.
